// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port word memory between the fetch and data requesters.
// Build with MEMARB_DPRIO_EN for fixed data priority; without it, arbitration is round robin.
module mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata_high,
    input  logic [DATA_WIDTH-1:0] d_wdata_low,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata_high,
    output logic [DATA_WIDTH-1:0] mem_wdata_low,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_data_read
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wh, lat_wl;
    logic lat_we, lat_d, grant_d, any_req, start, done;
    assign any_req = if_req | d_req;
    assign start   = state == IDLE && any_req;
    assign done    = state == BUSY && cnt == 4'd0;
`ifdef MEMARB_DPRIO_EN
    assign grant_d = d_req;
`else
    logic last_d;
    // On a tie the port that did not win last time is served
    assign grant_d = d_req & (~if_req | ~last_d);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_d <= 1'b0;
        else if (start) last_d <= grant_d;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = any_req ? BUSY : IDLE;
            BUSY:    state_nxt = done ? RESP : BUSY;
            default: state_nxt = IDLE;
        endcase
    end
    assign mem_address    = state == BUSY ? lat_addr : '0;
    assign mem_wdata_high = state == BUSY ? lat_wh : '0;
    assign mem_wdata_low  = state == BUSY ? lat_wl : '0;
    assign mem_we         = done & lat_we;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            lat_addr <= '0;
            lat_wh   <= '0;
            lat_wl   <= '0;
            lat_we   <= 1'b0;
            lat_d    <= 1'b0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            if (start) begin
                cnt      <= 4'(LATENCY - 1);
                lat_d    <= grant_d;
                lat_addr <= grant_d ? d_addr : if_addr;
                lat_wh   <= grant_d ? d_wdata_high : '0;
                lat_wl   <= grant_d ? d_wdata_low : '0;
                lat_we   <= grant_d & d_we;
            end else if (state == BUSY) begin
                if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else begin
                    if_ack <= ~lat_d;
                    d_ack  <= lat_d;
                    if (!lat_d) if_rdata <= mem_data_read;
                    else if (!lat_we) d_rdata <= mem_data_read;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a word-memory reference model.
module tb_mem_arbiter;
    localparam int DW = 16, AW = 16, LAT = 2;
    logic clk = 1'b0, rst_n = 1'b0;
    logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata_high = '0, d_wdata_low = '0;
    logic if_ack, d_ack, mem_we;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata_high, mem_wdata_low, mem_data_read;
    logic [AW-1:0] mem_address;
    logic f1_req = 1'b0;
    logic [AW-1:0] f1_addr = '0, zero_a = '0;
    logic [DW-1:0] zero_d = '0;
    logic f1_ack, d1_ack, mem1_we;
    logic [DW-1:0] f1_rdata, d1_rdata, mem1_wh, mem1_wl, mem1_rd;
    logic [AW-1:0] mem1_addr;
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    int wr_cnt = 0, vectors = 0, errs = 0;
    bit model_last_d = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata_high(d_wdata_high), .d_wdata_low(d_wdata_low),
        .d_ack(d_ack), .d_rdata(d_rdata), .mem_address(mem_address), .mem_wdata_high(mem_wdata_high),
        .mem_wdata_low(mem_wdata_low), .mem_we(mem_we), .mem_data_read(mem_data_read));

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .if_req(f1_req), .if_addr(f1_addr), .if_ack(f1_ack), .if_rdata(f1_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(zero_a), .d_wdata_high(zero_d), .d_wdata_low(zero_d),
        .d_ack(d1_ack), .d_rdata(d1_rdata), .mem_address(mem1_addr), .mem_wdata_high(mem1_wh),
        .mem_wdata_low(mem1_wl), .mem_we(mem1_we), .mem_data_read(mem1_rd));

    // Memory environment: high word at address, low word at address+1 (16-bit wrap)
    assign mem_data_read = mem[mem_address];
    assign mem1_rd = mem1_addr ^ 16'h5A5A;
    always @(posedge clk)
        if (mem_we) begin
            mem[mem_address] <= mem_wdata_high;
            mem[16'(mem_address + 16'd1)] <= mem_wdata_low;
            wr_cnt <= wr_cnt + 1;
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access from an idle arbiter with only one requester active
    task automatic access(input bit dport, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wh, input logic [DW-1:0] wl);
        int w0 = wr_cnt;
        logic [DW-1:0] exp_rd = ref_mem[a];
        logic [DW-1:0] keep_d = d_rdata;
        logic [DW-1:0] keep_f = if_rdata;
        if (dport) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata_high = wh; d_wdata_low = wl;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        if (we) begin
            ref_mem[a] = wh;
            ref_mem[16'(a + 16'd1)] = wl;
        end
        model_last_d = dport;
        tick();
        for (int c = 1; c <= LAT; c++) begin
            chk("busy_addr", mem_address, a);
            if (dport) chk("busy_wdata", {mem_wdata_high, mem_wdata_low}, {wh, wl});
            chk("early_ack", {if_ack, d_ack}, 0);
            if (dport) d_addr = AW'($urandom); else if_addr = AW'($urandom);
            tick();
        end
        chk("ack", {if_ack, d_ack}, dport ? 2'b01 : 2'b10);
        chk("resp_addr", mem_address, 0);
        chk("we_cycles", wr_cnt - w0, we);
        if (dport) begin
            chk("d_rdata", d_rdata, we ? keep_d : exp_rd);
            chk("if_rdata_hold", if_rdata, keep_f);
        end else chk("if_rdata", if_rdata, exp_rd);
        if_req = 1'b0;
        d_req = 1'b0;
        tick();
        chk("ack_drop", {if_ack, d_ack}, 0);
        tick();
        chk("idle_addr", mem_address, 0);
    endtask

    initial begin
        int n;
        bit w;
        logic [AW-1:0] fa, da, cur, nxt;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'(i) ^ 16'hC3A5;
            ref_mem[i] = 16'(i) ^ 16'hC3A5;
        end
        mem[16'h0010] = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;
        tick();
        tick();
        chk("rst_acks", {if_ack, d_ack}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        chk("rst_mem", {mem_address, mem_wdata_high, mem_wdata_low, 15'd0, mem_we}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", {mem_address, 15'd0, mem_we}, 0);

        access(1'b0, 1'b0, 16'h0010, '0, '0);
        chk("fetch_beef", if_rdata, 16'hBEEF);
        access(1'b1, 1'b1, 16'h0020, 16'h1234, 16'h5678);
        access(1'b1, 1'b0, 16'h0020, 16'h0BAD, 16'h0BAD);
        chk("rd_0020", d_rdata, 16'h1234);
        access(1'b0, 1'b0, 16'h0021, '0, '0);
        chk("rd_0021", if_rdata, 16'h5678);
        access(1'b1, 1'b1, 16'hFFFF, 16'hAAAA, 16'h5555);
        access(1'b1, 1'b0, 16'hFFFF, '0, '0);
        chk("wrap_hi", d_rdata, 16'hAAAA);
        access(1'b0, 1'b0, 16'h0000, '0, '0);
        chk("wrap_lo", if_rdata, 16'h5555);

        for (int k = 0; k < 24; k++) begin
            bit dp = 1'($urandom_range(0, 1));
            bit wr = dp & 1'($urandom_range(0, 1));
            logic [AW-1:0] a = 16'($urandom_range(0, 15)) + ($urandom_range(0, 1) ? 16'h0020 : 16'hFFF8);
            access(dp, wr, a, DW'($urandom), DW'($urandom));
        end

        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata_high = 16'hDEAD; d_wdata_low = 16'hF00D;
        tick();
        tick();
        chk("pre_rst_we", mem_we, 1);
        n = wr_cnt;
        #2;
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        chk("rst_we", mem_we, 0);
        chk("rst_idle", {mem_address, if_ack, d_ack}, 0);
        tick();
        chk("rst_no_write", wr_cnt - n, 0);
        chk("rst_mem_hi", mem[16'h0040], ref_mem[16'h0040]);
        chk("rst_mem_lo", mem[16'h0041], ref_mem[16'h0041]);
        rst_n = 1'b1;
        model_last_d = 1'b0;
        tick();

        fa = 16'h0010;
        da = 16'h0021;
        if_req = 1'b1; if_addr = fa;
        d_req = 1'b1; d_we = 1'b0; d_addr = da;
        for (int k = 0; k < 6; k++) begin
`ifdef MEMARB_DPRIO_EN
            w = 1'b1;
`else
            w = !model_last_d;
`endif
            n = 0;
            do begin
                tick();
                n++;
            end while (!(if_ack || d_ack) && n < 10);
            chk("arb_gap", n, k == 0 ? LAT + 1 : LAT + 2);
            chk("arb_winner", {if_ack, d_ack}, w ? 2'b01 : 2'b10);
            chk("arb_rdata", w ? d_rdata : if_rdata, ref_mem[w ? da : fa]);
            model_last_d = w;
        end
        if_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();

        cur = 16'h1234;
        f1_addr = cur;
        f1_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            nxt = AW'($urandom);
            f1_addr = nxt;
            #1;
            chk("l1_busy_addr", mem1_addr, cur);
            chk("l1_busy_ack", {f1_ack, mem1_we}, 0);
            tick();
            chk("l1_ack", f1_ack, 1);
            chk("l1_rdata", f1_rdata, cur ^ 16'h5A5A);
            tick();
            chk("l1_ack_drop", f1_ack, 0);
            cur = nxt;
        end
        f1_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
